// File: rtl/word_packer.sv
// Packs 0..IN_WORDS words per beat LSB-first into OUT_WORDS-wide lines, carrying overflow
// into the next line; a flush closes the current partial line and marks it last.
module word_packer #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned IN_WORDS  = 2,
    parameter int unsigned OUT_WORDS = 4
) (
    input  logic                                 i_clk,
    input  logic                                 i_reset,
    input  logic                                 i_valid,
    input  logic [$clog2(IN_WORDS+1)-1:0]        i_count,
    input  logic [IN_WORDS*WIDTH-1:0]            i_word,
    input  logic                                 i_flush,
    output logic                                 o_ready,
    output logic [OUT_WORDS*WIDTH-1:0]           o_word,
    output logic                                 o_valid,
    output logic [$clog2(OUT_WORDS+1)-1:0]       o_fill,
    output logic                                 o_last,
    input  logic                                 i_ready
);

    localparam int unsigned CNT_W   = $clog2(IN_WORDS + 1);
    localparam int unsigned FILL_W  = $clog2(OUT_WORDS + 1);
    localparam int unsigned ACC_N   = OUT_WORDS - 1;
    localparam int unsigned AF_W    = $clog2(OUT_WORDS);
    localparam int unsigned TOT_W   = $clog2(OUT_WORDS + IN_WORDS);
    localparam int unsigned O_WIDTH = OUT_WORDS * WIDTH;
    localparam int unsigned A_WIDTH = ACC_N * WIDTH;
    localparam int unsigned C_WIDTH = O_WIDTH + A_WIDTH;
    localparam int unsigned SH_W    = $clog2(C_WIDTH);

    localparam logic [0:0] ST_ACCUM      = 1'b0;
    localparam logic [0:0] ST_FLUSH_PEND = 1'b1;

    logic [0:0]          r_state;
    logic [A_WIDTH-1:0]  r_acc;
    logic [AF_W-1:0]     r_acc_fill;
    logic [O_WIDTH-1:0]  r_word;
    logic                r_valid;
    logic [FILL_W-1:0]   r_fill;
    logic                r_last;

    logic                w_out_free;
    logic                w_accept;
    logic [CNT_W-1:0]    w_n;
    logic [TOT_W-1:0]    w_total;
    logic                w_full;
    logic [IN_WORDS*WIDTH-1:0] w_in_mask;
    logic [A_WIDTH-1:0]  w_acc_mask;
    logic [SH_W-1:0]     w_shamt;
    logic [C_WIDTH-1:0]  w_comb;
    logic [O_WIDTH-1:0]  w_line;
    logic [A_WIDTH-1:0]  w_rem;
    logic [A_WIDTH-1:0]  w_low;

    assign w_out_free = ~r_valid | i_ready;
    assign o_ready    = i_reset & w_out_free & (r_state == ST_ACCUM);
    assign w_accept   = i_valid & o_ready;

    assign w_n     = (i_count > CNT_W'(IN_WORDS)) ? CNT_W'(IN_WORDS) : i_count;
    assign w_total = TOT_W'(r_acc_fill) + TOT_W'(w_n);
    assign w_full  = (w_total >= TOT_W'(OUT_WORDS));

    // Zero everything beyond the live words so partial lines come out with clean upper words.
    always_comb begin
        w_in_mask = '0;
        for (int k = 0; k < IN_WORDS; k++) begin
            if (CNT_W'(k) < w_n) w_in_mask[k*WIDTH +: WIDTH] = i_word[k*WIDTH +: WIDTH];
        end
        w_acc_mask = '0;
        for (int i = 0; i < ACC_N; i++) begin
            if (AF_W'(i) < r_acc_fill) w_acc_mask[i*WIDTH +: WIDTH] = r_acc[i*WIDTH +: WIDTH];
        end
    end

    assign w_shamt = SH_W'(r_acc_fill) * SH_W'(WIDTH);
    assign w_comb  = C_WIDTH'(w_acc_mask) | (C_WIDTH'(w_in_mask) << w_shamt);
    assign w_line  = w_comb[O_WIDTH-1:0];
    assign w_rem   = w_comb[C_WIDTH-1:O_WIDTH];
    assign w_low   = w_comb[A_WIDTH-1:0];

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state    <= ST_ACCUM;
            r_acc      <= '0;
            r_acc_fill <= '0;
            r_word     <= '0;
            r_valid    <= 1'b0;
            r_fill     <= '0;
            r_last     <= 1'b0;
        end else begin
            if (r_valid && i_ready) begin
                r_valid <= 1'b0;
                r_fill  <= '0;
                r_last  <= 1'b0;
            end
            if (r_state == ST_FLUSH_PEND) begin
                if (w_out_free) begin
                    r_word     <= O_WIDTH'(r_acc);
                    r_valid    <= 1'b1;
                    r_fill     <= FILL_W'(r_acc_fill);
                    r_last     <= 1'b1;
                    r_acc      <= '0;
                    r_acc_fill <= '0;
                    r_state    <= ST_ACCUM;
                end
            end else if (w_accept) begin
                if (w_full) begin
                    r_word     <= w_line;
                    r_valid    <= 1'b1;
                    r_fill     <= FILL_W'(OUT_WORDS);
                    r_last     <= i_flush && (w_total == TOT_W'(OUT_WORDS));
                    r_acc      <= w_rem;
                    r_acc_fill <= AF_W'(w_total - TOT_W'(OUT_WORDS));
                    // Overflowing flush: remainder goes out as a separate last line.
                    if (i_flush && (w_total > TOT_W'(OUT_WORDS))) r_state <= ST_FLUSH_PEND;
                end else if (i_flush && (w_total != '0)) begin
                    r_word     <= w_line;
                    r_valid    <= 1'b1;
                    r_fill     <= FILL_W'(w_total);
                    r_last     <= 1'b1;
                    r_acc      <= '0;
                    r_acc_fill <= '0;
                end else begin
                    r_acc      <= w_low;
                    r_acc_fill <= AF_W'(w_total);
                end
            end
        end
    end

    assign o_word  = r_word;
    assign o_valid = r_valid;
    assign o_fill  = r_fill;
    assign o_last  = r_last;

endmodule

// File: tb/tb_word_packer.sv
// Bench for word_packer: directed literal cases plus random traffic checked every cycle
// against a word-queue model of the packer.
module tb_word_packer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         v;
    logic [1:0]   cnt;
    logic [63:0]  w;
    logic         fl;
    logic         rdy;
    logic         dut_ready;
    logic [127:0] dut_word;
    logic         dut_valid;
    logic [2:0]   dut_fill;
    logic         dut_last;

    int n_vec = 0;
    int n_err = 0;

    // Model state: pending words in arrival order plus the output line register.
    logic [31:0]  q[$];
    logic [127:0] m_word;
    logic         m_valid;
    int           m_fill;
    logic         m_last;
    logic         m_pend;

    word_packer #(.WIDTH(32), .IN_WORDS(2), .OUT_WORDS(4)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .i_valid (v),
        .i_count (cnt),
        .i_word  (w),
        .i_flush (fl),
        .o_ready (dut_ready),
        .o_word  (dut_word),
        .o_valid (dut_valid),
        .o_fill  (dut_fill),
        .o_last  (dut_last),
        .i_ready (rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic emit(input int k);
        m_word = '0;
        for (int i = 0; i < k; i++) m_word[i*W +: W] = q.pop_front();
        m_fill  = k;
        m_valid = 1'b1;
    endtask

    task automatic model_edge();
        logic free;
        logic acc;
        int   n;
        free = !m_valid || rdy;
        acc  = v && rst_n && free && !m_pend;
        if (!rst_n) begin
            q.delete();
            m_word = '0; m_valid = 0; m_fill = 0; m_last = 0; m_pend = 0;
        end else begin
            if (m_valid && rdy) begin
                m_valid = 0; m_last = 0; m_fill = 0;
            end
            if (m_pend) begin
                if (free) begin
                    emit(q.size());
                    m_last = 1; m_pend = 0;
                end
            end else if (acc) begin
                n = (cnt > 2) ? 2 : int'(cnt);
                for (int k = 0; k < n; k++) q.push_back(w[k*W +: W]);
                if (q.size() >= 4) begin
                    emit(4);
                    m_last = fl && (q.size() == 0);
                    m_pend = fl && (q.size() > 0);
                end else if (fl && q.size() > 0) begin
                    emit(q.size());
                    m_last = 1;
                end
            end
        end
    endtask

    // One clock: drive at negedge, compare against the model, then advance both at posedge.
    task automatic step(input logic r, input logic vv, input logic [1:0] c,
                        input logic [63:0] ww, input logic f, input logic rd);
        @(negedge clk);
        rst_n = r; v = vv; cnt = c; w = ww; fl = f; rdy = rd;
        #1;
        chk("o_valid", 128'(dut_valid), 128'(m_valid));
        chk("o_word", dut_word, m_word);
        chk("o_fill", 128'(dut_fill), 128'(m_fill));
        chk("o_last", 128'(dut_last), 128'(m_last));
        chk("o_ready", 128'(dut_ready), 128'(rst_n && (!m_valid || rdy) && !m_pend));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic logic [127:0] line4(input int a, input int b, input int c, input int d);
        return {32'(d), 32'(c), 32'(b), 32'(a)};
    endfunction

    initial begin
        rst_n = 0; v = 1; cnt = 2; w = {32'd2, 32'd1}; fl = 0; rdy = 1;
        @(posedge clk);
        model_edge();
        #1;

        // Reset held with a valid beat presented
        repeat (2) begin
            step(0, 1, 2, {32'd2, 32'd1}, 0, 1);
            chk("rst_valid", 128'(dut_valid), 128'd0);
            chk("rst_word", dut_word, 128'd0);
            chk("rst_fill", 128'(dut_fill), 128'd0);
            chk("rst_ready", 128'(dut_ready), 128'd0);
        end
        step(1, 0, 0, 64'd0, 0, 1);
        chk("rel_ready", 128'(dut_ready), 128'd1);

        // Steady two words per beat
        step(1, 1, 2, {32'd2, 32'd1}, 0, 1);
        step(1, 1, 2, {32'd4, 32'd3}, 0, 1);
        chk("steady1", dut_word, line4(1, 2, 3, 4));
        chk("steady1_fill", 128'(dut_fill), 128'd4);
        chk("steady1_last", 128'(dut_last), 128'd0);
        step(1, 1, 2, {32'd6, 32'd5}, 0, 1);
        step(1, 1, 2, {32'd8, 32'd7}, 0, 1);
        chk("steady2", dut_word, line4(5, 6, 7, 8));
        chk("steady2_valid", 128'(dut_valid), 128'd1);

        // Odd counts with carry; upper word junk on count 1 must be ignored
        step(1, 1, 1, {32'hdead, 32'hA}, 0, 1);
        step(1, 1, 2, {32'hC, 32'hB}, 0, 1);
        step(1, 1, 2, {32'hE, 32'hD}, 0, 1);
        chk("odd1", dut_word, line4('hA, 'hB, 'hC, 'hD));
        step(1, 1, 2, {32'h16, 32'hF}, 0, 1);
        step(1, 1, 1, {32'hbeef, 32'h17}, 0, 1);
        chk("odd2", dut_word, line4('hE, 'hF, 'h16, 'h17));

        // Backpressure: line held for five cycles
        repeat (5) begin
            step(1, 1, 2, {32'h99, 32'h98}, 0, 0);
            chk("bp_ready", 128'(dut_ready), 128'd0);
            chk("bp_word", dut_word, line4('hE, 'hF, 'h16, 'h17));
            chk("bp_fill", 128'(dut_fill), 128'd4);
        end
        step(1, 0, 0, 64'd0, 0, 1);
        chk("bp_drained", 128'(dut_valid), 128'd0);

        // Partial flush with an empty flushing beat
        step(1, 1, 1, {32'h0, 32'hA}, 0, 1);
        step(1, 1, 2, {32'hC, 32'hB}, 0, 1);
        step(1, 1, 0, {32'h5, 32'h5}, 1, 1);
        chk("fp_word", dut_word, line4('hA, 'hB, 'hC, 0));
        chk("fp_fill", 128'(dut_fill), 128'd3);
        chk("fp_last", 128'(dut_last), 128'd1);

        // Overflowing flush
        step(1, 1, 2, {32'hB, 32'hA}, 0, 1);
        step(1, 1, 1, {32'h0, 32'hC}, 0, 1);
        step(1, 1, 2, {32'hE, 32'hD}, 1, 1);
        chk("fo_word", dut_word, line4('hA, 'hB, 'hC, 'hD));
        chk("fo_last", 128'(dut_last), 128'd0);
        chk("fo_ready", 128'(dut_ready), 128'd0);
        step(1, 0, 0, 64'd0, 0, 1);
        chk("fo_rem", dut_word, line4('hE, 0, 0, 0));
        chk("fo_rem_fill", 128'(dut_fill), 128'd1);
        chk("fo_rem_last", 128'(dut_last), 128'd1);
        chk("fo_ready_back", 128'(dut_ready), 128'd1);

        // Reset while a flush remainder is pending
        step(1, 1, 2, {32'hB, 32'hA}, 0, 1);
        step(1, 1, 1, {32'h0, 32'hC}, 0, 1);
        step(1, 1, 2, {32'hE, 32'hD}, 1, 1);
        step(0, 0, 0, 64'd0, 0, 1);
        chk("mr_valid", 128'(dut_valid), 128'd0);
        chk("mr_word", dut_word, 128'd0);
        chk("mr_fill", 128'(dut_fill), 128'd0);
        chk("mr_last", 128'(dut_last), 128'd0);
        step(1, 1, 2, {32'd2, 32'd1}, 0, 1);
        step(1, 1, 2, {32'd4, 32'd3}, 0, 1);
        chk("mr_line", dut_word, line4(1, 2, 3, 4));

        // Random traffic, including clamped counts and occasional resets
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 9) < 7),
                 2'($urandom_range(0, 3)),
                 {$urandom(), $urandom()},
                 ($urandom_range(0, 99) < 15),
                 ($urandom_range(0, 9) < 6));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
